sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Shares the single SDRAM controller port between the audio requesters: recorder, player and `PitchCore`. It grants one requester at a time and latches that requester's command, address and write data. It forwards the command to the SDRAM controller and routes the `finished` handshake back to the granted requester only. It sits between the requester modules and the SDRAM controller in the top level and is driven by the same `i_clk`/`i_rst`.

## Interface
- `NUM_REQ`, default 3: number of requesters; index 0 = player, 1 = recorder, 2 = pitch core.
- `ADDR_W`, default 23: SDRAM word address width.
- `DATA_W`, default 32: SDRAM data width.

- `i_clk`  in  1  system clock; sole clock of the block.
- `i_rst`  in  1  reset, synchronous, active-high.
- `req_read`  in  NUM_REQ  per-requester read request; level, held until that requester's `req_finished`.
- `req_write`  in  NUM_REQ  per-requester write request; same holding rule.
- `req_addr`  in  ADDR_W x NUM_REQ  per-requester address.
- `req_writedata`  in  DATA_W x NUM_REQ  per-requester write data.
- `req_readdata`  out  DATA_W  broadcast of `sdram_readdata`; valid only with that requester's `req_finished` on a read.
- `req_finished`  out  NUM_REQ  one-hot completion strobe, one cycle.
- `grant`  out  NUM_REQ  one-hot, registered; current owner, all-zero when idle.
- `busy`  out  1  a transaction is in flight.
- `sdram_read`, `sdram_write`  out  1 each  command to the SDRAM controller, registered.
- `sdram_addr`  out  ADDR_W  registered.
- `sdram_writedata`  out  DATA_W  registered.
- `sdram_readdata`  in  DATA_W  from the SDRAM controller.
- `sdram_finished`  in  1  one-cycle completion strobe from the SDRAM controller.

## Operation
- Two states: IDLE and BUSY.
- **IDLE**
  - A requester is pending when its `req_read | req_write` is high.
  - If any requester is pending, pick winner `w` by round-robin: search circularly starting at `last+1`, where `last` is the last granted index.
  - At the next edge: latch `req_addr[w]`/`req_writedata[w]` into `sdram_addr`/`sdram_writedata`; set `sdram_write = req_write[w]` and `sdram_read = req_read[w] & ~req_write[w]` (write wins on a protocol error); set `grant[w]=1`, `busy=1`, `last=w`; go to BUSY.
- **BUSY**
  - Command outputs are held constant. Requester inputs are ignored, including changes by the owner.
  - `req_finished = grant & {NUM_REQ{sdram_finished}}`, combinational.
  - On `sdram_finished`, at the next edge: clear `sdram_read`, `sdram_write`, `grant` and `busy`; return to IDLE.
- The mandatory IDLE cycle after each transaction lets the owner drop its request before re-arbitration, so a finished request is never re-granted.
- `sdram_finished` while in IDLE is ignored and `req_finished` stays 0.
- Requests that arrive during BUSY wait. They are never lost because they are level-held.
- Reset values: all outputs 0, state IDLE, `last = NUM_REQ-1` so requester 0 wins first.
- Reset mid-transaction abandons it with no `req_finished`. The SDRAM controller shares `i_rst` and is reset in the same cycle.

## Timing
- The request is seen in IDLE at cycle t. `grant`, `busy` and the `sdram_*` command are high from t+1.
- `sdram_finished` arrives at cycle f ≥ t+1. `req_finished` is high in cycle f only, and `req_readdata` is valid in f.
- The command drops at f+1 (state IDLE). The next grant is at f+2 at the earliest.
- Back-to-back throughput: one transaction per (SDRAM latency + 2) cycles.
- Starvation bound under round-robin: a pending requester is granted within NUM_REQ-1 other transactions.

## Configuration
- `SDRAM_ARB_PRIORITY_EN`
  - Defined: requester 0 (player, real-time) has absolute priority. If `req_*[0]` is pending in IDLE it wins regardless of `last`; the others use round-robin among themselves. `last` is updated only by non-zero grants.
  - Undefined: pure round-robin over all requesters, as described above.

## Test plan
- Reset, then single read on requester 2, address 0x1234, SDRAM returns 0xDEADBEEF after 5 cycles. Expect `sdram_read`/`sdram_addr=0x1234` from t+1, `req_finished=3'b100` for exactly one cycle with `req_readdata=0xDEADBEEF`, `grant=0` one cycle later.
- All three requesters hold writes continuously. Expect grant order 0,1,2,0,1,2 with one idle cycle between transactions, and each `sdram_writedata` matches the granted requester.
- Requester 1 asserts read and write together with data 0x5A5A5A5A. Expect `sdram_write=1`, `sdram_read=0`.
- Owner changes `req_addr` mid-BUSY. Expect `sdram_addr` unchanged until `sdram_finished`.
- Assert `i_rst` during BUSY. Expect all outputs 0 next cycle, no `req_finished`, and the next grant goes to requester 0.
- With `SDRAM_ARB_PRIORITY_EN`, requesters 0 and 2 both pending continuously. Expect requester 0 granted every transaction; without the macro, 0 and 2 alternate.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Bundle of requester-side and SDRAM-controller-side signals for sdram_arbiter.
// slave = arbiter view, master = surrounding requesters plus SDRAM controller.
interface sdram_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 23,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]             req_read;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_writedata;
  logic [DATA_W-1:0]              req_readdata;
  logic [NUM_REQ-1:0]             req_finished;
  logic [NUM_REQ-1:0]             grant;
  logic                           busy;
  logic                           sdram_read;
  logic                           sdram_write;
  logic [ADDR_W-1:0]              sdram_addr;
  logic [DATA_W-1:0]              sdram_writedata;
  logic [DATA_W-1:0]              sdram_readdata;
  logic                           sdram_finished;

  modport slave (
    input  req_read, req_write, req_addr, req_writedata, sdram_readdata, sdram_finished,
    output req_readdata, req_finished, grant, busy,
    output sdram_read, sdram_write, sdram_addr, sdram_writedata
  );

  modport master (
    output req_read, req_write, req_addr, req_writedata, sdram_readdata, sdram_finished,
    input  req_readdata, req_finished, grant, busy,
    input  sdram_read, sdram_write, sdram_addr, sdram_writedata
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among the audio requesters.
// Optional macro SDRAM_ARB_PRIORITY_EN gives requester 0 (player) absolute priority.
module sdram_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 23,
  parameter int unsigned DATA_W  = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  sdram_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic [NUM_REQ-1:0] pending;
  logic               found;
  logic [IdxW-1:0]    win;
  logic [IdxW-1:0]    idx_n;
  int unsigned        idx;

  // Circular search starting just after the last granted index.
  always_comb begin
    pending = bus.req_read | bus.req_write;
    found   = 1'b0;
    win     = '0;
    idx     = 0;
    idx_n   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx   = (32'(last_q) + k) % NUM_REQ;
      idx_n = idx[IdxW-1:0];
      if (!found && pending[idx_n]) begin
        found = 1'b1;
        win   = idx_n;
      end
    end
`ifdef SDRAM_ARB_PRIORITY_EN
    if (pending[0]) begin
      found = 1'b1;
      win   = '0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d      = StBusy;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          busy_d       = 1'b1;
          // A simultaneous read+write from one requester is resolved as a write.
          wr_d         = bus.req_write[win];
          rd_d         = bus.req_read[win] & ~bus.req_write[win];
          addr_d       = bus.req_addr[win];
          wdata_d      = bus.req_writedata[win];
`ifdef SDRAM_ARB_PRIORITY_EN
          if (win != '0) last_d = win;
`else
          last_d       = win;
`endif
        end
      end
      StBusy: begin
        if (bus.sdram_finished) begin
          state_d = StIdle;
          grant_d = '0;
          busy_d  = 1'b0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      last_q  <= IdxW'(NUM_REQ - 1);
      grant_q <= '0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.grant           = grant_q;
  assign bus.busy            = busy_q;
  assign bus.sdram_read      = rd_q;
  assign bus.sdram_write     = wr_q;
  assign bus.sdram_addr      = addr_q;
  assign bus.sdram_writedata = wdata_q;
  assign bus.req_readdata    = bus.sdram_readdata;
  // grant_q is only non-zero while busy, so stray completions in idle never leak out.
  assign bus.req_finished    = grant_q & {NUM_REQ{bus.sdram_finished}};

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter; honours SDRAM_ARB_PRIORITY_EN.
module tb_sdram_arbiter;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sdram_arbiter_if bus ();

  sdram_arbiter dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset;
    bus.req_read       = '0;
    bus.req_write      = '0;
    bus.req_addr       = '0;
    bus.req_writedata  = '0;
    bus.sdram_readdata = '0;
    bus.sdram_finished = 1'b0;
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++; if (bus.grant !== 3'b000) begin errors++;
      $display("FAIL reset_grant: got %b expected 000", bus.grant); end
    checks++; if ({bus.busy, bus.sdram_read, bus.sdram_write} !== 3'b000) begin errors++;
      $display("FAIL reset_ctrl: got %b expected 000",
               {bus.busy, bus.sdram_read, bus.sdram_write}); end
    checks++; if (bus.sdram_addr !== 23'h0 || bus.sdram_writedata !== 32'h0) begin errors++;
      $display("FAIL reset_data: got %h/%h expected 0/0", bus.sdram_addr,
               bus.sdram_writedata); end
    bus.sdram_finished = 1'b1;
    #1;
    checks++; if (bus.req_finished !== 3'b000) begin errors++;
      $display("FAIL idle_finished: got %b expected 000", bus.req_finished); end
    tick();
    bus.sdram_finished = 1'b0;
    checks++; if ({bus.busy, bus.grant} !== 4'b0000) begin errors++;
      $display("FAIL idle_no_grant: got %b expected 0000", {bus.busy, bus.grant}); end
  endtask

  task automatic test_single_read;
    apply_reset();
    bus.req_read[2] = 1'b1;
    bus.req_addr[2] = 23'h1234;
    tick();
    checks++; if (bus.grant !== 3'b100 || bus.busy !== 1'b1) begin errors++;
      $display("FAIL single_grant: got %b/%b expected 100/1", bus.grant, bus.busy); end
    checks++; if (bus.sdram_read !== 1'b1 || bus.sdram_write !== 1'b0) begin errors++;
      $display("FAIL single_cmd: got rd=%b wr=%b expected rd=1 wr=0", bus.sdram_read,
               bus.sdram_write); end
    checks++; if (bus.sdram_addr !== 23'h1234) begin errors++;
      $display("FAIL single_addr: got %h expected 1234", bus.sdram_addr); end
    repeat (4) tick();
    checks++; if (bus.req_finished !== 3'b000) begin errors++;
      $display("FAIL single_early_fin: got %b expected 000", bus.req_finished); end
    bus.sdram_finished = 1'b1;
    bus.sdram_readdata = 32'hDEADBEEF;
    #1;
    checks++; if (bus.req_finished !== 3'b100) begin errors++;
      $display("FAIL single_fin: got %b expected 100", bus.req_finished); end
    checks++; if (bus.req_readdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL single_rdata: got %h expected deadbeef", bus.req_readdata); end
    tick();
    checks++; if (bus.req_finished !== 3'b000) begin errors++;
      $display("FAIL single_fin_once: got %b expected 000", bus.req_finished); end
    checks++; if ({bus.busy, bus.grant, bus.sdram_read} !== 5'b0) begin errors++;
      $display("FAIL single_release: got %b expected 00000",
               {bus.busy, bus.grant, bus.sdram_read}); end
    bus.sdram_finished = 1'b0;
    bus.req_read[2]    = 1'b0;
    tick();
    checks++; if (bus.grant !== 3'b000) begin errors++;
      $display("FAIL single_no_regrant: got %b expected 000", bus.grant); end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp;
    int         e;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      bus.req_writedata[i] = 32'hA000_0000 + 32'(i);
      bus.req_addr[i]      = 23'(16 * i);
    end
    bus.req_write = 3'b111;
    for (int n = 0; n < 6; n++) begin
`ifdef SDRAM_ARB_PRIORITY_EN
      e = 0;
`else
      e = n % 3;
`endif
      exp = 3'(1 << e);
      tick();
      checks++; if (bus.grant !== exp) begin errors++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", n, bus.grant, exp); end
      checks++; if (bus.sdram_writedata !== 32'hA000_0000 + 32'(e) || bus.sdram_write !== 1'b1)
        begin errors++;
        $display("FAIL rr_wdata[%0d]: got %h wr=%b expected %h wr=1", n,
                 bus.sdram_writedata, bus.sdram_write, 32'hA000_0000 + 32'(e)); end
      tick();
      bus.sdram_finished = 1'b1;
      #1;
      checks++; if (bus.req_finished !== exp) begin errors++;
        $display("FAIL rr_fin[%0d]: got %b expected %b", n, bus.req_finished, exp); end
      tick();
      bus.sdram_finished = 1'b0;
      checks++; if ({bus.busy, bus.grant} !== 4'b0000) begin errors++;
        $display("FAIL rr_idle[%0d]: got %b expected 0000", n, {bus.busy, bus.grant}); end
    end
    bus.req_write = '0;
  endtask

  task automatic test_protocol_error;
    apply_reset();
    bus.req_read[1]      = 1'b1;
    bus.req_write[1]     = 1'b1;
    bus.req_writedata[1] = 32'h5A5A5A5A;
    bus.req_addr[1]      = 23'h42;
    tick();
    checks++; if (bus.grant !== 3'b010) begin errors++;
      $display("FAIL perr_grant: got %b expected 010", bus.grant); end
    checks++; if (bus.sdram_write !== 1'b1 || bus.sdram_read !== 1'b0) begin errors++;
      $display("FAIL perr_cmd: got wr=%b rd=%b expected wr=1 rd=0", bus.sdram_write,
               bus.sdram_read); end
    checks++; if (bus.sdram_writedata !== 32'h5A5A5A5A) begin errors++;
      $display("FAIL perr_wdata: got %h expected 5a5a5a5a", bus.sdram_writedata); end
    tick();
    bus.sdram_finished = 1'b1;
    #1;
    checks++; if (bus.req_finished !== 3'b010) begin errors++;
      $display("FAIL perr_fin: got %b expected 010", bus.req_finished); end
    tick();
    bus.sdram_finished = 1'b0;
    bus.req_read       = '0;
    bus.req_write      = '0;
    checks++; if (bus.sdram_write !== 1'b0) begin errors++;
      $display("FAIL perr_drop: got %b expected 0", bus.sdram_write); end
  endtask

  task automatic test_addr_hold;
    apply_reset();
    bus.req_read[0] = 1'b1;
    bus.req_addr[0] = 23'h100;
    tick();
    checks++; if (bus.sdram_addr !== 23'h100 || bus.grant !== 3'b001) begin errors++;
      $display("FAIL hold_start: got %h/%b expected 100/001", bus.sdram_addr, bus.grant); end
    bus.req_addr[0]      = 23'h7FFFFF;
    bus.req_write[0]     = 1'b1;
    bus.req_writedata[0] = 32'h12345678;
    repeat (3) tick();
    checks++; if (bus.sdram_addr !== 23'h100) begin errors++;
      $display("FAIL hold_addr: got %h expected 100", bus.sdram_addr); end
    checks++; if (bus.sdram_read !== 1'b1 || bus.sdram_write !== 1'b0
                  || bus.sdram_writedata !== 32'h0) begin errors++;
      $display("FAIL hold_cmd: got rd=%b wr=%b wd=%h expected rd=1 wr=0 wd=0",
               bus.sdram_read, bus.sdram_write, bus.sdram_writedata); end
    bus.sdram_finished = 1'b1;
    #1;
    checks++; if (bus.sdram_addr !== 23'h100 || bus.req_finished !== 3'b001) begin errors++;
      $display("FAIL hold_fin: got %h/%b expected 100/001", bus.sdram_addr,
               bus.req_finished); end
    tick();
    bus.sdram_finished = 1'b0;
    bus.req_read       = '0;
    bus.req_write      = '0;
  endtask

  task automatic test_reset_busy;
    apply_reset();
    bus.req_read[2] = 1'b1;
    bus.req_addr[2] = 23'h55;
    tick();
    checks++; if (bus.grant !== 3'b100) begin errors++;
      $display("FAIL rstb_grant: got %b expected 100", bus.grant); end
    bus.req_read[0] = 1'b1;
    tick();
    i_rst = 1'b1;
    tick();
    checks++; if ({bus.grant, bus.busy, bus.sdram_read, bus.sdram_write} !== 6'b0) begin
      errors++;
      $display("FAIL rstb_outputs: got %b expected 000000",
               {bus.grant, bus.busy, bus.sdram_read, bus.sdram_write}); end
    checks++; if (bus.sdram_addr !== 23'h0) begin errors++;
      $display("FAIL rstb_addr: got %h expected 0", bus.sdram_addr); end
    bus.sdram_finished = 1'b1;
    #1;
    checks++; if (bus.req_finished !== 3'b000) begin errors++;
      $display("FAIL rstb_no_fin: got %b expected 000", bus.req_finished); end
    i_rst = 1'b0;
    tick();
    bus.sdram_finished = 1'b0;
    checks++; if (bus.grant !== 3'b001) begin errors++;
      $display("FAIL rstb_regrant: got %b expected 001", bus.grant); end
    tick();
    bus.sdram_finished = 1'b1;
    tick();
    bus.sdram_finished = 1'b0;
    bus.req_read       = '0;
  endtask

  task automatic test_priority;
    logic [2:0] exp;
    apply_reset();
    bus.req_read[0] = 1'b1;
    bus.req_read[2] = 1'b1;
    for (int n = 0; n < 4; n++) begin
`ifdef SDRAM_ARB_PRIORITY_EN
      exp = 3'b001;
`else
      exp = (n % 2 == 1) ? 3'b100 : 3'b001;
`endif
      tick();
      checks++; if (bus.grant !== exp) begin errors++;
        $display("FAIL prio_grant[%0d]: got %b expected %b", n, bus.grant, exp); end
      bus.sdram_finished = 1'b1;
      #1;
      checks++; if (bus.req_finished !== exp) begin errors++;
        $display("FAIL prio_fin[%0d]: got %b expected %b", n, bus.req_finished, exp); end
      tick();
      bus.sdram_finished = 1'b0;
    end
    bus.req_read = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_protocol_error();
    test_addr_hold();
    test_reset_busy();
    test_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
